warp_scheduler: RTL and testbench

- Round-robin issue scheduler for one compute unit.
- Consumes per-warp ready flags and PCs from the warp_state array.
- Picks one ready warp per cycle and drives the selected warp's pc_update_en so that warp advances its PC.
- Presents the chosen warp ID and PC to the instruction-fetch stage through a valid/ready issue register.

---
 rtl/cu_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/warp_scheduler.sv | 143 ++++++++++++++
 tb/tb_warp_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared compute-unit definitions: default sizes, ID-width helper and scheduler states.
package cu_pkg;

  localparam int NUM_WARPS_DEFAULT = 4;
  localparam int PC_WIDTH_DEFAULT  = 8;

  function automatic int wid_width_f(input int num_warps);
    return (num_warps <= 1) ? 1 : $clog2(num_warps);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand_s;
  logic         found_s;

  // Scan N candidates starting one past the pointer; N is a power of two so W-bit wrap is modulo N.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= N; i++) begin
      cand_s = ptr + W'(i);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp issue scheduler with a valid/ready issue register toward fetch.
// Optional WARP_SCHED_PERF_CNT_EN adds saturating issue/stall performance counters.
module warp_scheduler
  import cu_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEFAULT,
  parameter int PC_WIDTH  = PC_WIDTH_DEFAULT,
  parameter int WID_WIDTH = wid_width_f(NUM_WARPS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sched_en,
  input  logic [NUM_WARPS-1:0]          warp_ready,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
  output logic [NUM_WARPS-1:0]          pc_update_en,
  output logic                          issue_valid,
  output logic [WID_WIDTH-1:0]          issue_warp_id,
  output logic [PC_WIDTH-1:0]           issue_pc,
  input  logic                          fetch_ready
`ifdef WARP_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]                   perf_issue_cnt,
  output logic [15:0]                   perf_stall_cnt
`endif
);

  sched_state_t         state_q, state_d;
  logic [WID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [WID_WIDTH-1:0] issue_warp_id_q, issue_warp_id_d;
  logic [PC_WIDTH-1:0]  issue_pc_q, issue_pc_d;
  logic [NUM_WARPS-1:0] busy_mask_s, elig_s, gnt_s;
  logic [WID_WIDTH-1:0] gnt_idx_s;
  logic [PC_WIDTH-1:0]  gnt_pc_s;
  logic                 load_s;

  // The warp sitting in a stalled issue register must not be granted again.
  always_comb begin
    busy_mask_s = '0;
    if (state_q == FULL && !fetch_ready) begin
      busy_mask_s[issue_warp_id_q] = 1'b1;
    end else begin
      busy_mask_s = '0;
    end
    elig_s = warp_ready & {NUM_WARPS{sched_en}} & ~busy_mask_s;
    load_s = ((state_q == EMPTY) || fetch_ready) && (elig_s != '0);
  end

  rr_arbiter #(
    .N (NUM_WARPS),
    .W (WID_WIDTH)
  ) u_rr_arbiter (
    .req (elig_s),
    .ptr (rr_ptr_q),
    .gnt (gnt_s),
    .idx (gnt_idx_s)
  );

  assign gnt_pc_s     = warp_pc[int'(gnt_idx_s)*PC_WIDTH +: PC_WIDTH];
  // Gated by reset so no warp advances while the scheduler is held in reset.
  assign pc_update_en = (load_s && reset) ? gnt_s : '0;

  // Next-state and issue-register capture.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    issue_warp_id_d = issue_warp_id_q;
    issue_pc_d      = issue_pc_q;
    if (load_s) begin
      rr_ptr_d        = gnt_idx_s;
      issue_warp_id_d = gnt_idx_s;
      issue_pc_d      = gnt_pc_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      EMPTY: begin
        if (load_s) state_d = FULL;
        else        state_d = EMPTY;
      end
      FULL: begin
        if (load_s)           state_d = FULL;
        else if (fetch_ready) state_d = EMPTY;
        else                  state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and issue register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= EMPTY;
      rr_ptr_q        <= WID_WIDTH'(NUM_WARPS - 1);
      issue_warp_id_q <= '0;
      issue_pc_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      issue_warp_id_q <= issue_warp_id_d;
      issue_pc_q      <= issue_pc_d;
    end
  end

  assign issue_valid   = (state_q == FULL);
  assign issue_warp_id = issue_warp_id_q;
  assign issue_pc      = issue_pc_q;

`ifdef WARP_SCHED_PERF_CNT_EN
  logic [15:0] perf_issue_cnt_q, perf_issue_cnt_d;
  logic [15:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Saturating counters: transfers and back-pressured cycles.
  always_comb begin
    perf_issue_cnt_d = perf_issue_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (state_q == FULL && fetch_ready && perf_issue_cnt_q != 16'hFFFF) begin
      perf_issue_cnt_d = perf_issue_cnt_q + 16'd1;
    end else begin
      perf_issue_cnt_d = perf_issue_cnt_q;
    end
    if (state_q == FULL && !fetch_ready && perf_stall_cnt_q != 16'hFFFF) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 16'd1;
    end else begin
      perf_stall_cnt_d = perf_stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issue_cnt_q <= 16'd0;
      perf_stall_cnt_q <= 16'd0;
    end else begin
      perf_issue_cnt_q <= perf_issue_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_issue_cnt = perf_issue_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed self-checking bench for warp_scheduler (4 warps, 8-bit PCs).
// Perf-counter scenario is compiled only with WARP_SCHED_PERF_CNT_EN.
module tb_warp_scheduler;

  logic        clk;
  logic        reset;
  logic        sched_en;
  logic [3:0]  warp_ready;
  logic [31:0] warp_pc;
  logic [3:0]  pc_update_en;
  logic        issue_valid;
  logic [1:0]  issue_warp_id;
  logic [7:0]  issue_pc;
  logic        fetch_ready;
`ifdef WARP_SCHED_PERF_CNT_EN
  logic [15:0] perf_issue_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int checks;
  int failures;
  logic [7:0] pcs [4];

  warp_scheduler #(.NUM_WARPS(4), .PC_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .sched_en      (sched_en),
    .warp_ready    (warp_ready),
    .warp_pc       (warp_pc),
    .pc_update_en  (pc_update_en),
    .issue_valid   (issue_valid),
    .issue_warp_id (issue_warp_id),
    .issue_pc      (issue_pc),
    .fetch_ready   (fetch_ready)
`ifdef WARP_SCHED_PERF_CNT_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; warp_ready = 4'b0000; sched_en = 1'b1; fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int exp_g [5];
    exp_g = '{0, 1, 2, 3, 0};
    @(negedge clk);
    reset = 1'b0; sched_en = 1'b1; warp_ready = 4'b1111; fetch_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (issue_valid !== 1'b0 || issue_warp_id !== 2'd0 || issue_pc !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b id=%0d pc=%h, required 0/0/00", issue_valid, issue_warp_id, issue_pc);
    end
    checks++;
    if (pc_update_en !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pc_update_en: got %b, required 0000", pc_update_en);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (pc_update_en !== (4'b0001 << exp_g[k])) begin
        failures++;
        $display("FAIL reset_grant[%0d]: pc_update_en=%b, required warp %0d", k, pc_update_en, exp_g[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (issue_valid !== 1'b1 || issue_warp_id !== 2'(exp_g[k]) || issue_pc !== pcs[exp_g[k]]) begin
        failures++;
        $display("FAIL reset_issue[%0d]: valid=%b id=%0d pc=%h, required 1/%0d/%h", k, issue_valid, issue_warp_id, issue_pc, exp_g[k], pcs[exp_g[k]]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rotation();
    int exp_g [4];
    exp_g = '{1, 3, 1, 3};
    do_reset();
    warp_ready = 4'b1010; fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (pc_update_en !== (4'b0001 << exp_g[k])) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: pc_update_en=%b, required warp %0d", k, pc_update_en, exp_g[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (issue_warp_id !== 2'(exp_g[k]) || issue_pc !== pcs[exp_g[k]]) begin
        failures++;
        $display("FAIL rotation_issue[%0d]: id=%0d pc=%h, required %0d/%h", k, issue_warp_id, issue_pc, exp_g[k], pcs[exp_g[k]]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    warp_ready = 4'b0100; fetch_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_warp_id !== 2'd2 || issue_pc !== 8'h10) begin
      failures++;
      $display("FAIL bp_first: valid=%b id=%0d pc=%h, required 1/2/10", issue_valid, issue_warp_id, issue_pc);
    end
    @(negedge clk);
    warp_ready = 4'b1111; fetch_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (pc_update_en !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold_grant[%0d]: pc_update_en=%b, required 0000", k, pc_update_en);
      end
      @(posedge clk); #1;
      checks++;
      if (issue_valid !== 1'b1 || issue_warp_id !== 2'd2 || issue_pc !== 8'h10) begin
        failures++;
        $display("FAIL bp_hold_issue[%0d]: valid=%b id=%0d pc=%h, required 1/2/10", k, issue_valid, issue_warp_id, issue_pc);
      end
      @(negedge clk);
    end
    fetch_ready = 1'b1;
    #1;
    checks++;
    if (pc_update_en !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release_grant: pc_update_en=%b, required 1000", pc_update_en);
    end
    @(posedge clk); #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_warp_id !== 2'd3 || issue_pc !== 8'h1C) begin
      failures++;
      $display("FAIL bp_release_issue: valid=%b id=%0d pc=%h, required 1/3/1c", issue_valid, issue_warp_id, issue_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_single_warp();
    do_reset();
    warp_ready = 4'b0001; fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (pc_update_en !== 4'b0001) begin
        failures++;
        $display("FAIL single_grant[%0d]: pc_update_en=%b, required 0001", k, pc_update_en);
      end
      @(posedge clk); #1;
      checks++;
      if (issue_valid !== 1'b1 || issue_warp_id !== 2'd0 || issue_pc !== 8'h04) begin
        failures++;
        $display("FAIL single_issue[%0d]: valid=%b id=%0d pc=%h, required 1/0/04", k, issue_valid, issue_warp_id, issue_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_disable_drain();
    // Continues from the FULL state left by test_single_warp.
    sched_en = 1'b0; warp_ready = 4'b1111; fetch_ready = 1'b0;
    #1;
    checks++;
    if (pc_update_en !== 4'b0000) begin
      failures++;
      $display("FAIL dis_grant_hold: pc_update_en=%b, required 0000", pc_update_en);
    end
    @(posedge clk); #1;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("FAIL dis_hold_valid: valid=%b, required 1", issue_valid);
    end
    @(negedge clk);
    fetch_ready = 1'b1;
    #1;
    checks++;
    if (pc_update_en !== 4'b0000) begin
      failures++;
      $display("FAIL dis_grant_drain: pc_update_en=%b, required 0000", pc_update_en);
    end
    @(posedge clk); #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL dis_drain_valid: valid=%b, required 0", issue_valid);
    end
    @(negedge clk);
    sched_en = 1'b1; warp_ready = 4'b0000; fetch_ready = 1'b1;
    #1;
    checks++;
    if (pc_update_en !== 4'b0000) begin
      failures++;
      $display("FAIL empty_ready_grant: pc_update_en=%b, required 0000", pc_update_en);
    end
    @(posedge clk); #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_stays_empty: valid=%b, required 0", issue_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    warp_ready = 4'b1111; sched_en = 1'b1; fetch_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup: valid=%b, required 1", issue_valid);
    end
    @(negedge clk);
    reset = 1'b0; fetch_ready = 1'b1;
    #1;
    checks++;
    if (issue_valid !== 1'b0 || pc_update_en !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_discard: valid=%b pc_update_en=%b, required 0/0000", issue_valid, pc_update_en);
    end
    @(negedge clk);
    reset = 1'b1; warp_ready = 4'b0000;
  endtask

`ifdef WARP_SCHED_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    #1;
    checks++;
    if (perf_issue_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset: issue=%0d stall=%0d, required 0/0", perf_issue_cnt, perf_stall_cnt);
    end
    @(negedge clk);
    warp_ready = 4'b0001; fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    repeat (3) @(negedge clk);
    fetch_ready = 1'b1;
    repeat (4) @(negedge clk);
    warp_ready = 4'b0000;
    @(negedge clk);
    checks++;
    if (perf_issue_cnt !== 16'd5 || perf_stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL perf_counts: issue=%0d stall=%0d, required 5/3", perf_issue_cnt, perf_stall_cnt);
    end
    warp_ready = 4'b0001; fetch_ready = 1'b1;
    @(negedge clk);
    warp_ready = 4'b0000; fetch_ready = 1'b0;
    repeat (65540) @(negedge clk);
    checks++;
    if (perf_stall_cnt !== 16'hFFFF || perf_issue_cnt !== 16'd5) begin
      failures++;
      $display("FAIL perf_saturate: issue=%0d stall=%h, required 5/ffff", perf_issue_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    pcs = '{8'h04, 8'h08, 8'h10, 8'h1C};
    warp_pc = {8'h1C, 8'h10, 8'h08, 8'h04};
    reset = 1'b0; sched_en = 1'b0; warp_ready = 4'b0000; fetch_ready = 1'b0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_single_warp();
    test_disable_drain();
    test_mid_reset();
`ifdef WARP_SCHED_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
